// File: rtl/decode_cycle.sv
// Decode stage of the 5-stage RV32I pipeline: control decode, register file,
// immediate generation and the ID/EX pipeline register feeding execute.
module decode_cycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        PredictionD,
  input  logic        StallD,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic [2:0]  BranchOpE,
  output logic        ALUSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RS1E,
  output logic [4:0]  RS2E,
  output logic [4:0]  RDE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic        PredictionE,
  output logic        IllegalE
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic        memWrite;
    logic        jump;
    logic        branch;
    logic [2:0]  branchOp;
    logic        aluSrc;
    logic [2:0]  aluControl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] immExt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        prediction;
    logic        illegal;
  } idExT;

  function automatic idExT bubbleFn();
    idExT b;
    b         = '0;
    b.pc      = RESET_PC;
    b.pcPlus4 = RESET_PC;
    return b;
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immJ, immU;
  logic [2:0]  aluFn;
  logic        aluOk;
  idExT        dec;
  idExT        idEx;
  logic [31:0] regFile [NUM_REGS];

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign immI   = {{20{InstrD[31]}}, InstrD[31:20]};
  assign immS   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign immB   = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign immJ   = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
  assign immU   = {InstrD[31:12], 12'b0};

  // ALU function shared by R-type and I-ALU; funct7[5] selects sub only for R-type
  always_comb begin
    aluFn = ALU_ADD;
    aluOk = 1'b1;
    case (funct3)
      3'b000:  aluFn = (opcode == OP_R && InstrD[30]) ? ALU_SUB : ALU_ADD;
      3'b111:  aluFn = ALU_AND;
      3'b110:  aluFn = ALU_OR;
      3'b100:  aluFn = ALU_XOR;
      3'b010:  aluFn = ALU_SLT;
      default: aluOk = 1'b0;
    endcase
  end

  always_comb begin
    dec            = '0;
    dec.rs1        = InstrD[19:15];
    dec.rs2        = InstrD[24:20];
    dec.rd         = InstrD[11:7];
    dec.pc         = PCD;
    dec.pcPlus4    = PCPlus4D;
    dec.prediction = PredictionD;
    case (opcode)
      OP_R: begin
        if (aluOk) begin
          dec.regWrite   = 1'b1;
          dec.aluControl = aluFn;
        end else dec.illegal = 1'b1;
      end
      OP_IMM: begin
        if (aluOk) begin
          dec.regWrite   = 1'b1;
          dec.aluSrc     = 1'b1;
          dec.aluControl = aluFn;
          dec.immExt     = immI;
        end else dec.illegal = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec.regWrite  = 1'b1;
          dec.resultSrc = 2'b01;
          dec.aluSrc    = 1'b1;
          dec.immExt    = immI;
        end else dec.illegal = 1'b1;
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec.memWrite = 1'b1;
          dec.aluSrc   = 1'b1;
          dec.immExt   = immS;
        end else dec.illegal = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b101) begin
          dec.branch     = 1'b1;
          dec.branchOp   = funct3;
          dec.aluControl = ALU_SUB;
          dec.immExt     = immB;
        end else dec.illegal = 1'b1;
      end
      OP_JAL: begin
        dec.regWrite  = 1'b1;
        dec.jump      = 1'b1;
        dec.resultSrc = 2'b10;
        dec.immExt    = immJ;
      end
      OP_LUI: begin
        dec.regWrite = 1'b1;
        dec.aluSrc   = 1'b1;
        dec.immExt   = immU;
        dec.rs1      = 5'd0;
      end
      // An all-zero word is a fetch-side bubble, so it is not flagged
      default: dec.illegal = (InstrD != 32'd0);
    endcase
    dec.rd1 = (dec.rs1 == 5'd0) ? 32'd0 :
              (RegWriteW && RDW == dec.rs1) ? ResultW : regFile[dec.rs1];
    dec.rd2 = (dec.rs2 == 5'd0) ? 32'd0 :
              (RegWriteW && RDW == dec.rs2) ? ResultW : regFile[dec.rs2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= 32'd0;
    end else if (RegWriteW && RDW != 5'd0) begin
      regFile[RDW] <= ResultW;
    end
  end

  // ID/EX register: flush beats stall, stall holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          idEx <= bubbleFn();
    else if (FlushE)  idEx <= bubbleFn();
    else if (!StallD) idEx <= dec;
  end

  assign RegWriteE   = idEx.regWrite;
  assign ResultSrcE  = idEx.resultSrc;
  assign MemWriteE   = idEx.memWrite;
  assign JumpE       = idEx.jump;
  assign BranchE     = idEx.branch;
  assign BranchOpE   = idEx.branchOp;
  assign ALUSrcE     = idEx.aluSrc;
  assign ALUControlE = idEx.aluControl;
  assign RD1E        = idEx.rd1;
  assign RD2E        = idEx.rd2;
  assign ImmExtE     = idEx.immExt;
  assign RS1E        = idEx.rs1;
  assign RS2E        = idEx.rs2;
  assign RDE         = idEx.rd;
  assign PCE         = idEx.pc;
  assign PCPlus4E    = idEx.pcPlus4;
  assign PredictionE = idEx.prediction;
  assign IllegalE    = idEx.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed testbench for decode_cycle: reset, WB bypass, x0, branch/flush,
// stall, decode of jal/lui/sw/sub/illegal, and asynchronous mid-run reset.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        PredictionD, StallD, FlushE, RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, PredictionE, IllegalE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  BranchOpE, ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RS1E, RS2E, RDE;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI_X6_X5_M1 = 32'hFFF28313;
  localparam logic [31:0] ADDI_X7_X0_0  = 32'h00000393;
  localparam logic [31:0] ADDI_X0_X9_0  = 32'h00048013;
  localparam logic [31:0] BEQ_X1_X2_M8  = 32'hFE208CE3;
  localparam logic [31:0] JAL_X0_M4     = 32'hFFDFF06F;
  localparam logic [31:0] LUI_X3        = 32'h123451B7;
  localparam logic [31:0] SW_X5_M12_X2  = 32'hFE512A23;
  localparam logic [31:0] SUB_X3_X1_X2  = 32'h402081B3;
  localparam logic [31:0] ECALL         = 32'h00000073;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PredictionD(PredictionD), .StallD(StallD), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .BranchOpE(BranchOpE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .PredictionE(PredictionE), .IllegalE(IllegalE)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; InstrD = 32'd0; PCD = 32'd0; PCPlus4D = 32'd0; PredictionD = 1'b0;
    StallD = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'd0;
    #2;
    checks++; if (RegWriteE !== 1'b0) begin errors++; $display("[TB] FAIL reset_regwrite: got %b expected 0", RegWriteE); end
    checks++; if (PCE !== 32'd0) begin errors++; $display("[TB] FAIL reset_pce: got %h expected 0", PCE); end
    checks++; if (IllegalE !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b expected 0", IllegalE); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hDEADBEEF; InstrD = ADDI_X6_X5_M1;
    tick();
    RegWriteW = 1'b0;
    checks++; if (RD1E !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL bypass_rd1: got %h expected deadbeef", RD1E); end
    checks++; if (ImmExtE !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL bypass_imm: got %h expected ffffffff", ImmExtE); end
    checks++; if (ALUSrcE !== 1'b1) begin errors++; $display("[TB] FAIL bypass_alusrc: got %b expected 1", ALUSrcE); end
    checks++; if (RegWriteE !== 1'b1) begin errors++; $display("[TB] FAIL bypass_regwrite: got %b expected 1", RegWriteE); end
    checks++; if ({RS1E, RDE} !== {5'd5, 5'd6}) begin errors++; $display("[TB] FAIL bypass_idx: got rs1=%0d rd=%0d expected 5 6", RS1E, RDE); end
    tick();
    checks++; if (RD1E !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rf_x5: got %h expected deadbeef", RD1E); end
  endtask

  task automatic test_x0();
    RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h1234; InstrD = ADDI_X7_X0_0;
    tick();
    RegWriteW = 1'b0;
    checks++; if (RD1E !== 32'd0) begin errors++; $display("[TB] FAIL x0_bypass: got %h expected 0", RD1E); end
    tick();
    checks++; if (RD1E !== 32'd0) begin errors++; $display("[TB] FAIL x0_read: got %h expected 0", RD1E); end
  endtask

  task automatic test_branch_flush();
    RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'h11;
    tick();
    RDW = 5'd2; ResultW = 32'h22;
    tick();
    RegWriteW = 1'b0;
    InstrD = BEQ_X1_X2_M8; PCD = 32'h40; PCPlus4D = 32'h44; PredictionD = 1'b1;
    tick();
    checks++; if (BranchE !== 1'b1) begin errors++; $display("[TB] FAIL beq_branch: got %b expected 1", BranchE); end
    checks++; if (ImmExtE !== 32'hFFFFFFF8) begin errors++; $display("[TB] FAIL beq_imm: got %h expected fffffff8", ImmExtE); end
    checks++; if (PCE !== 32'h40 || PCPlus4E !== 32'h44) begin errors++; $display("[TB] FAIL beq_pc: got %h/%h expected 40/44", PCE, PCPlus4E); end
    checks++; if (PredictionE !== 1'b1) begin errors++; $display("[TB] FAIL beq_pred: got %b expected 1", PredictionE); end
    checks++; if ({RegWriteE, ALUControlE, BranchOpE} !== {1'b0, 3'b001, 3'b000}) begin errors++; $display("[TB] FAIL beq_ctrl: got rw=%b alu=%b op=%b expected 0 001 000", RegWriteE, ALUControlE, BranchOpE); end
    checks++; if (RD1E !== 32'h11 || RD2E !== 32'h22) begin errors++; $display("[TB] FAIL beq_ops: got %h/%h expected 11/22", RD1E, RD2E); end
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    checks++; if ({BranchE, RegWriteE, PredictionE, IllegalE} !== 4'b0000) begin errors++; $display("[TB] FAIL flush_ctrl: got %b expected 0000", {BranchE, RegWriteE, PredictionE, IllegalE}); end
    checks++; if (PCE !== 32'd0 || ImmExtE !== 32'd0) begin errors++; $display("[TB] FAIL flush_data: got pc=%h imm=%h expected 0 0", PCE, ImmExtE); end
  endtask

  task automatic test_stall();
    InstrD = ADDI_X6_X5_M1; PCD = 32'h100; PCPlus4D = 32'h104; PredictionD = 1'b0;
    tick();
    StallD = 1'b1; InstrD = BEQ_X1_X2_M8; PCD = 32'h200; PCPlus4D = 32'h204;
    RegWriteW = 1'b1; RDW = 5'd9; ResultW = 32'h99;
    tick();
    RegWriteW = 1'b0;
    tick();
    checks++; if (PCE !== 32'h100) begin errors++; $display("[TB] FAIL stall_pc: got %h expected 100", PCE); end
    checks++; if (ImmExtE !== 32'hFFFFFFFF || RD1E !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL stall_data: got imm=%h rd1=%h expected ffffffff deadbeef", ImmExtE, RD1E); end
    checks++; if ({RegWriteE, BranchE} !== 2'b10) begin errors++; $display("[TB] FAIL stall_ctrl: got %b expected 10", {RegWriteE, BranchE}); end
    StallD = 1'b0; InstrD = ADDI_X0_X9_0;
    tick();
    checks++; if (RD1E !== 32'h99) begin errors++; $display("[TB] FAIL stall_rfwrite: got %h expected 99", RD1E); end
    StallD = 1'b1; FlushE = 1'b1; InstrD = ADDI_X6_X5_M1; PCD = 32'h300;
    tick();
    StallD = 1'b0; FlushE = 1'b0;
    checks++; if ({RegWriteE, ALUSrcE} !== 2'b00 || PCE !== 32'd0 || RD1E !== 32'd0) begin errors++; $display("[TB] FAIL stall_flush: got rw/as=%b pc=%h rd1=%h expected 00 0 0", {RegWriteE, ALUSrcE}, PCE, RD1E); end
  endtask

  task automatic test_decode_misc();
    InstrD = ECALL;
    tick();
    checks++; if ({IllegalE, RegWriteE, MemWriteE} !== 3'b100) begin errors++; $display("[TB] FAIL illegal_ecall: got %b expected 100", {IllegalE, RegWriteE, MemWriteE}); end
    InstrD = 32'd0;
    tick();
    checks++; if ({IllegalE, RegWriteE} !== 2'b00) begin errors++; $display("[TB] FAIL zero_word: got %b expected 00", {IllegalE, RegWriteE}); end
    InstrD = JAL_X0_M4;
    tick();
    checks++; if (ImmExtE !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL jal_imm: got %h expected fffffffc", ImmExtE); end
    checks++; if ({JumpE, ResultSrcE, RegWriteE} !== 4'b1101) begin errors++; $display("[TB] FAIL jal_ctrl: got %b expected 1101", {JumpE, ResultSrcE, RegWriteE}); end
    InstrD = LUI_X3;
    tick();
    checks++; if (ImmExtE !== 32'h12345000) begin errors++; $display("[TB] FAIL lui_imm: got %h expected 12345000", ImmExtE); end
    checks++; if (RS1E !== 5'd0 || {ALUSrcE, RegWriteE, ALUControlE} !== 5'b11000) begin errors++; $display("[TB] FAIL lui_ctrl: got rs1=%0d ctl=%b expected 0 11000", RS1E, {ALUSrcE, RegWriteE, ALUControlE}); end
    InstrD = SW_X5_M12_X2;
    tick();
    checks++; if (ImmExtE !== 32'hFFFFFFF4) begin errors++; $display("[TB] FAIL sw_imm: got %h expected fffffff4", ImmExtE); end
    checks++; if ({MemWriteE, RegWriteE, ALUSrcE} !== 3'b101) begin errors++; $display("[TB] FAIL sw_ctrl: got %b expected 101", {MemWriteE, RegWriteE, ALUSrcE}); end
    InstrD = SUB_X3_X1_X2;
    tick();
    checks++; if ({ALUControlE, ALUSrcE, RegWriteE} !== 5'b00101) begin errors++; $display("[TB] FAIL sub_ctrl: got %b expected 00101", {ALUControlE, ALUSrcE, RegWriteE}); end
  endtask

  task automatic test_async_reset();
    InstrD = LUI_X3; PCD = 32'h500;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if ({RegWriteE, ALUSrcE} !== 2'b00 || PCE !== 32'd0 || ImmExtE !== 32'd0) begin errors++; $display("[TB] FAIL async_reset: got ctl=%b pc=%h imm=%h expected 00 0 0", {RegWriteE, ALUSrcE}, PCE, ImmExtE); end
    @(negedge clk);
    rst = 1'b0; InstrD = ADDI_X6_X5_M1;
    tick();
    checks++; if (RD1E !== 32'd0) begin errors++; $display("[TB] FAIL reset_x5: got %h expected 0", RD1E); end
    checks++; if (ImmExtE !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL reset_resume: got %h expected ffffffff", ImmExtE); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0();
    test_branch_flush();
    test_stall();
    test_decode_misc();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
